// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared encodings and defaults for the interrupt controller
package irq_pkg;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // PCSrc code the control decoder issues when it takes an interrupt
  localparam logic [2:0] PCSRC_IRQ = 3'b100;

  // Default channel count
  localparam int N_IRQ_DEFAULT = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder with valid flag
import irq_pkg::*;

module irq_prio_enc #(
  parameter int N    = N_IRQ_DEFAULT,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last write and wins
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - masked priority interrupt controller with req/ack handshake (IRQ_LEVEL_EN selects level-sensitive channels)
import irq_pkg::*;

module irq_ctrl #(
  parameter int               N_IRQ    = N_IRQ_DEFAULT,
  parameter int               ID_W     = 2,
  parameter int               PC_W     = 32,
  parameter logic [N_IRQ-1:0] MASK_RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic [N_IRQ-1:0] mask_rdata,
  output logic [N_IRQ-1:0] pending,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic [PC_W-1:0]  pc_in,
  output logic [PC_W-1:0]  epc,
  input  logic             eret,
  output logic             in_service
);

  irq_state_e       state_q, state_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [PC_W-1:0]  epc_q, epc_d;

  logic [N_IRQ-1:0] eligible;
  logic             enc_valid;
  logic [ID_W-1:0]  enc_idx;
  logic             ack_fire;

  // Arbitration always uses registered pending and mask, so a same-cycle
  // mask write only takes effect on the following arbitration
  assign eligible = pending_q & mask_q;
  assign ack_fire = (state_q == REQ) && irq_ack;

  irq_prio_enc #(
    .N    (N_IRQ),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Software mask register
  always_comb begin
    mask_d = mask_q;
    if (mask_we) begin
      mask_d = mask_wdata;
    end
  end

`ifdef IRQ_LEVEL_EN
  // Level mode: pending simply mirrors the synchronised lines one cycle late
  always_comb begin
    pending_d = irq_in;
  end
`else
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] ack_clr;

  assign rise = irq_in & ~irq_q;

  // Edge mode: latch rises; a rise coincident with the ack clear wins
  always_comb begin
    ack_clr = '0;
    if (ack_fire) begin
      ack_clr = N_IRQ'(1) << irq_id_q;
    end
    pending_d = (pending_q & ~ack_clr) | rise;
  end

  // Previous-cycle copy of the lines for rise detection
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_in;
    end
  end
`endif

  // Next-state logic: request is frozen once raised, no nesting in service
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    epc_d    = epc_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d  = REQ;
          irq_id_d = enc_idx;
        end
      end
      REQ: begin
        if (ack_fire) begin
          state_d = SERVICE;
          epc_d   = pc_in;
        end
      end
      SERVICE: begin
        if (eret) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= MASK_RST;
      pending_q <= '0;
      irq_id_q  <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      irq_id_q  <= irq_id_d;
      epc_q     <= epc_d;
    end
  end

  assign mask_rdata = mask_q;
  assign pending    = pending_q;
  assign irq_req    = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign irq_id     = irq_id_q;
  assign epc        = epc_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic [3:0]  mask_rdata;
  logic [3:0]  pending;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic        irq_ack;
  logic [31:0] pc_in;
  logic [31:0] epc;
  logic        eret;
  logic        in_service;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  irq_ctrl #(
    .N_IRQ    (4),
    .ID_W     (2),
    .PC_W     (32),
    .MASK_RST (4'b0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_rdata (mask_rdata),
    .pending    (pending),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .pc_in      (pc_in),
    .epc        (epc),
    .eret       (eret),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    irq_ack = 1'b0; pc_in = '0; eret = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_mask", 32'(mask_rdata), 32'h0);
    check("rst_req", 32'(irq_req), 32'h0);
    check("rst_id", 32'(irq_id), 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_insvc", 32'(in_service), 32'h0);

`ifdef IRQ_LEVEL_EN
    mask_we = 1'b1; mask_wdata = 4'b1111; step(); mask_we = 1'b0;
    irq_in = 4'b0100;
    step();
    check("lvl_pending", 32'(pending), 32'h4);
    step();
    check("lvl_req1", 32'(irq_req), 32'h1);
    check("lvl_id1", 32'(irq_id), 32'h2);
    irq_ack = 1'b1; pc_in = 32'h0000_0200; step(); irq_ack = 1'b0;
    check("lvl_pend_held", 32'(pending), 32'h4);
    eret = 1'b1; step(); eret = 1'b0;
    check("lvl_idle", 32'(irq_req), 32'h0);
    step();
    check("lvl_req2", 32'(irq_req), 32'h1);
    check("lvl_id2", 32'(irq_id), 32'h2);
    irq_in = 4'b0000;
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    eret = 1'b1; step(); eret = 1'b0;
    step();
    check("lvl_noreq1", 32'(irq_req), 32'h0);
    step();
    check("lvl_noreq2", 32'(irq_req), 32'h0);
`else
    // Masked pulse latches but does not request
    irq_in = 4'b0100; step(); irq_in = 4'b0000;
    check("t1_pending", 32'(pending), 32'h4);
    step();
    check("t1_noreq", 32'(irq_req), 32'h0);
    mask_we = 1'b1; mask_wdata = 4'b1111; step(); mask_we = 1'b0;
    check("t1_mask", 32'(mask_rdata), 32'hF);
    check("t1_req_early", 32'(irq_req), 32'h0);
    step();
    check("t1_req", 32'(irq_req), 32'h1);
    check("t1_id", 32'(irq_id), 32'h2);
    irq_ack = 1'b1; pc_in = 32'h0000_0100; step(); irq_ack = 1'b0;
    check("t1_pend_clr", 32'(pending), 32'h0);
    eret = 1'b1; step(); eret = 1'b0;
    check("t1_eret", 32'(in_service), 32'h0);

    // Two simultaneous rises, lowest index wins
    irq_in = 4'b1010; step(); irq_in = 4'b0000;
    check("t2_latency", 32'(irq_req), 32'h0);
    step();
    check("t2_req", 32'(irq_req), 32'h1);
    check("t2_id", 32'(irq_id), 32'h1);
    irq_ack = 1'b1; pc_in = 32'h0040_0010; step(); irq_ack = 1'b0;
    check("t2_epc", epc, 32'h0040_0010);
    check("t2_pending", 32'(pending), 32'h8);
    check("t2_insvc", 32'(in_service), 32'h1);
    check("t2_req_drop", 32'(irq_req), 32'h0);

    // No nesting in service; stray ack ignored; re-arbitrate after eret
    irq_in = 4'b0001; step(); irq_in = 4'b0000;
    step();
    check("t3_noreq", 32'(irq_req), 32'h0);
    check("t3_pending", 32'(pending), 32'h9);
    irq_ack = 1'b1; pc_in = 32'hDEAD_BEEF; step(); irq_ack = 1'b0;
    check("t3_ack_ign_pend", 32'(pending), 32'h9);
    check("t3_ack_ign_epc", epc, 32'h0040_0010);
    check("t3_ack_ign_svc", 32'(in_service), 32'h1);
    eret = 1'b1; step(); eret = 1'b0;
    check("t3_eret_svc", 32'(in_service), 32'h0);
    check("t3_idle_gap", 32'(irq_req), 32'h0);
    step();
    check("t3_req", 32'(irq_req), 32'h1);
    check("t3_id", 32'(irq_id), 32'h0);

    // Frozen request despite mask clear and higher-priority arrival
    irq_ack = 1'b1; pc_in = 32'h0000_0300; step(); irq_ack = 1'b0;
    irq_in = 4'b0010; step(); irq_in = 4'b0000;
    eret = 1'b1; step(); eret = 1'b0;
    step();
    check("t4_req", 32'(irq_req), 32'h1);
    check("t4_id", 32'(irq_id), 32'h1);
    mask_we = 1'b1; mask_wdata = 4'b0000; step(); mask_we = 1'b0;
    check("t4_mask0", 32'(mask_rdata), 32'h0);
    check("t4_req_hold", 32'(irq_req), 32'h1);
    irq_in = 4'b0001; step(); irq_in = 4'b0000;
    check("t4_id_frozen", 32'(irq_id), 32'h1);
    check("t4_req_hold2", 32'(irq_req), 32'h1);
    check("t4_pend_hi", 32'(pending), 32'hB);
    irq_in = 4'b0010; irq_ack = 1'b1; pc_in = 32'h0040_0020; step();
    irq_in = 4'b0000; irq_ack = 1'b0;
    check("t4_set_wins", 32'(pending), 32'hB);
    check("t4_epc", epc, 32'h0040_0020);
    check("t4_insvc", 32'(in_service), 32'h1);

    // Reset while in service
    reset = 1'b1; step(); reset = 1'b0;
    check("t5_epc", epc, 32'h0);
    check("t5_insvc", 32'(in_service), 32'h0);
    check("t5_req", 32'(irq_req), 32'h0);
    check("t5_pending", 32'(pending), 32'h0);
    check("t5_mask", 32'(mask_rdata), 32'h0);
    check("t5_id", 32'(irq_id), 32'h0);
    eret = 1'b1; step(); eret = 1'b0;
    check("t5_eret_ign", 32'(in_service), 32'h0);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("t5_ack_ign", 32'(in_service), 32'h0);
    check("t5_ack_ign_req", 32'(irq_req), 32'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller feeding the IRQ input of the pipeline control decoder.
- Latches up to N_IRQ external interrupt sources and applies a software mask.
- Selects the highest-priority pending source and runs a request/acknowledge handshake with the pipeline.
- Captures the exception PC on acknowledge and holds in-service state until ERET.

Parameters:
- N_IRQ, 4, number of interrupt channels (1..32).
- ID_W, 2, width of irq_id; must satisfy 2**ID_W >= N_IRQ.
- PC_W, 32, width of captured PC.
- MASK_RST, 0, reset value of the mask register (bit=1 enables the channel).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  N_IRQ  raw interrupt lines, already synchronised to clk.
- mask_we  in  1  mask register write strobe.
- mask_wdata  in  N_IRQ  new mask value.
- mask_rdata  out  N_IRQ  current mask.
- pending  out  N_IRQ  current pending bits.
- irq_req  out  1  interrupt request to control; drives IRQ.
- irq_id  out  ID_W  channel being requested or serviced.
- irq_ack  in  1  pipeline accepted the interrupt (PCSrc=100 issued).
- pc_in  in  PC_W  PC of the interrupted instruction, sampled on ack.
- epc  out  PC_W  captured return PC.
- eret  in  1  handler return.
- in_service  out  1  handler active.

Behaviour:
- Reset values: pending=0, mask=MASK_RST, irq_req=0, irq_id=0, epc=0, in_service=0, state=IDLE, edge-detect register=0.
- Edge detection: register irq_q <= irq_in. A rise is irq_in & ~irq_q; it sets the corresponding pending bit the next cycle.
- A pending bit is set regardless of mask; the mask gates selection only.
- Selection: eligible = pending & mask. Lowest index has highest priority.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If eligible != 0, go to REQ next cycle.
  - On that transition, register irq_id = index of the highest-priority eligible bit and set irq_req=1.
  - Latency: rise on irq_in to irq_req high is 2 cycles.
- REQ:
  - irq_req stays 1 and irq_id stays frozen until irq_ack. No retraction, even if the mask is cleared or a higher-priority source arrives.
  - On irq_ack: irq_req=0, in_service=1, epc<=pc_in, pending[irq_id] cleared, go to SERVICE.
- SERVICE:
  - New rises keep setting pending bits. No request is raised (no nesting).
  - On eret: in_service=0, go to IDLE. Re-arbitration happens in the following cycle, so back-to-back interrupts take 1 idle cycle.
- Simultaneous events:
  - Rise on channel k in the same cycle pending[k] is cleared by ack: the set wins and the bit stays 1.
  - mask_we in the same cycle as arbitration: arbitration uses the old mask.
- Ignored inputs:
  - irq_ack outside REQ has no effect.
  - eret outside SERVICE has no effect.
- mask_rdata reflects a write the cycle after mask_we.
- Reset mid-operation: any state returns to IDLE next edge. All pending bits and epc are cleared and outputs take reset values.
- irq_id is held after SERVICE until the next arbitration.

Optional Feature:
- Macro: IRQ_LEVEL_EN.
- Defined: channels are level-sensitive.
  - pending = irq_in registered every cycle; there is no latch, and ack does not clear it.
  - The source must drop before eret or it re-requests.
- Undefined: edge-latched behaviour as above.

Decomposition:
- Shared package irq_pkg holds:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
  - PCSrc interrupt code 3'b100.
  - Default N_IRQ.
- One sub-module, irq_prio_enc: parametrised lowest-index-first priority encoder producing a valid flag and index.

Test Plan:
- Reset with MASK_RST=0; pulse irq_in[2] for 1 cycle -> pending=4'b0100, irq_req stays 0. Then write mask=4'b1111 -> irq_req=1, irq_id=2 two cycles after the write.
- mask=4'b1111; rise irq_in[3] and irq_in[1] in the same cycle -> irq_req=1, irq_id=1 after 2 cycles. Ack with pc_in=32'h0040_0010 -> epc=32'h0040_0010, pending=4'b1000, in_service=1.
- In SERVICE, rise irq_in[0] -> irq_req stays 0, pending[0]=1. eret -> in_service=0; the next cycle irq_req=1, irq_id=0.
- In REQ with irq_id=1, write mask=4'b0000 -> irq_req still 1 until ack. Rise on irq_in[1] coincident with ack -> pending[1] remains 1.
- Assert reset while in SERVICE with epc=32'h0040_0020 -> next cycle epc=0, in_service=0, irq_req=0, pending=0. eret afterward has no effect.
- IRQ_LEVEL_EN defined: hold irq_in[2]=1 through ack and eret -> second request with irq_id=2 one cycle after returning to IDLE. Drop irq_in[2] -> no further request.
